// File: rtl/prog_sync_fifo_if.sv
// Producer/consumer handshake bundle for prog_sync_fifo.
// master: the side that writes/reads the FIFO; slave: the FIFO itself.
interface prog_sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 6
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wdata, rd_en,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/prog_sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty thresholds and registered overflow/underflow pulses.
// Compile-time option: define FIFO_FWFT_EN for first-word-fall-through reads
// (head word presented combinationally, rd_en acts as pop acknowledge).
module prog_sync_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 6,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic           clk,
    input  logic           rst,
    prog_sync_fifo_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  full_c;
    logic                  empty_c;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  overflow_q;
    logic                  underflow_q;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status flags decode the registered occupancy.
    assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);

    // A read frees a slot, so a write at full is accepted alongside it.
    assign rd_acc = bus.rd_en && !empty_c;
    assign wr_acc = bus.wr_en && (!full_c || rd_acc);

    // Next occupancy from accepted accesses.
    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
            count_q     <= count_d;
            overflow_q  <= bus.wr_en && !wr_acc;
            underflow_q <= bus.rd_en && !rd_acc;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.wdata;
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through; valid whenever the FIFO holds data.
    assign bus.rdata  = mem[rd_ptr];
    assign bus.rvalid = !empty_c;
`else
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // Registered read port; rdata holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= mem[rd_ptr];
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`endif

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_prog_sync_fifo.sv
// Self-checking bench for prog_sync_fifo (DEPTH=6, AFULL=5, AEMPTY=1).
// Works in both the default build and the FIFO_FWFT_EN build.
module tb_prog_sync_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Reference model: occupancy and expected-data queue.
    int             mcount;
    logic [DW-1:0]  sb[$];

    prog_sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    prog_sync_fifo #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .AFULL_THRESH (DEPTH - 1),
        .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock of stimulus; model predicts, scoreboard pops on read output.
    task automatic drive(input logic we, input logic [DW-1:0] wd, input logic re);
        bit            racc, wacc, exp_ovf, exp_udf;
        logic [DW-1:0] exp_d;
        bus.wr_en = we;
        bus.wdata = wd;
        bus.rd_en = re;
        racc = re && (mcount != 0);
        wacc = we && ((mcount != int'(DEPTH)) || racc);
        exp_d = '0;
        if (racc) exp_d = sb[0];
`ifdef FIFO_FWFT_EN
        #1;
        tests_run++;
        if (racc && bus.rdata !== exp_d) begin
            tests_failed++;
            $display("FAIL fwft_head: got %h expected %h", bus.rdata, exp_d);
        end
`endif
        @(posedge clk);
        if (racc) void'(sb.pop_front());
        if (wacc) sb.push_back(wd);
        mcount  = mcount + int'(wacc && !racc) - int'(racc && !wacc);
        exp_ovf = we && !wacc;
        exp_udf = re && !racc;
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tests_run++;
        if (bus.count !== CW'(mcount)) begin
            tests_failed++;
            $display("FAIL count: got %0d expected %0d", bus.count, mcount);
        end
        tests_run++;
        if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty} !==
            {mcount == int'(DEPTH), mcount == 0, mcount >= int'(DEPTH) - 1, mcount <= 1}) begin
            tests_failed++;
            $display("FAIL flags(f,e,af,ae): got %b%b%b%b count_model %0d",
                     bus.full, bus.empty, bus.almost_full, bus.almost_empty, mcount);
        end
        tests_run++;
        if ({bus.overflow, bus.underflow} !== {exp_ovf, exp_udf}) begin
            tests_failed++;
            $display("FAIL err_pulse(ovf,udf): got %b%b expected %b%b",
                     bus.overflow, bus.underflow, exp_ovf, exp_udf);
        end
`ifdef FIFO_FWFT_EN
        tests_run++;
        if (bus.rvalid !== (mcount != 0)) begin
            tests_failed++;
            $display("FAIL rvalid: got %b expected %b", bus.rvalid, mcount != 0);
        end
`else
        tests_run++;
        if (bus.rvalid !== racc) begin
            tests_failed++;
            $display("FAIL rvalid: got %b expected %b", bus.rvalid, racc);
        end
        if (racc) begin
            tests_run++;
            if (bus.rdata !== exp_d) begin
                tests_failed++;
                $display("FAIL rdata: got %h expected %h", bus.rdata, exp_d);
            end
        end
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && mcount > 0; i++) drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
             bus.rvalid, bus.overflow, bus.underflow} !== {CW'(0), 7'b1100000}) begin
            tests_failed++;
            $display("FAIL reset_state: count %0d e %b ae %b f %b af %b rv %b ovf %b udf %b",
                     bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full,
                     bus.rvalid, bus.overflow, bus.underflow);
        end
`ifndef FIFO_FWFT_EN
        tests_run++;
        if (bus.rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected 00", bus.rdata);
        end
`endif
        rst = 1'b0;
        mcount = 0;
        sb.delete();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, DW'(8'h11 + i), 1'b0);
            tests_run++;
            if (bus.almost_full !== (i >= 4)) begin
                tests_failed++;
                $display("FAIL fill_afull: write %0d got %b expected %b", i, bus.almost_full, i >= 4);
            end
        end
        tests_run++;
        if ({bus.full, bus.count} !== {1'b1, CW'(6)}) begin
            tests_failed++;
            $display("FAIL fill_full: full %b count %0d expected 1 6", bus.full, bus.count);
        end
        drain();
        tests_run++;
        if (bus.empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_empty: got %b expected 1", bus.empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) drive(1'b1, DW'(8'h11 + i), 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        tests_run++;
        if ({bus.overflow, bus.count} !== {1'b1, CW'(6)}) begin
            tests_failed++;
            $display("FAIL overflow_pulse: ovf %b count %0d expected 1 6", bus.overflow, bus.count);
        end
        drive(1'b0, '0, 1'b0);
        tests_run++;
        if (bus.overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear: got %b expected 0", bus.overflow);
        end
    endtask

    task automatic test_full_rw();
        drive(1'b1, 8'hBB, 1'b1);
        tests_run++;
        if (bus.count !== CW'(6)) begin
            tests_failed++;
            $display("FAIL full_rw_count: got %0d expected 6", bus.count);
        end
`ifndef FIFO_FWFT_EN
        tests_run++;
        if (bus.rdata !== 8'h11) begin
            tests_failed++;
            $display("FAIL full_rw_rdata: got %h expected 11", bus.rdata);
        end
`endif
        drain();
    endtask

    task automatic test_empty_rw();
        drive(1'b1, 8'h5C, 1'b1);
        tests_run++;
        if ({bus.underflow, bus.count} !== {1'b1, CW'(1)}) begin
            tests_failed++;
            $display("FAIL empty_rw: udf %b count %0d expected 1 1", bus.underflow, bus.count);
        end
        drive(1'b0, '0, 1'b1);
`ifndef FIFO_FWFT_EN
        tests_run++;
        if (bus.rdata !== 8'h5C) begin
            tests_failed++;
            $display("FAIL empty_rw_read: got %h expected 5c", bus.rdata);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++)
            drive($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 55);
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'h21 + i), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcount = 0;
        sb.delete();
        tests_run++;
        if ({bus.count, bus.empty, bus.rvalid} !== {CW'(0), 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid: count %0d empty %b rvalid %b expected 0 1 0",
                     bus.count, bus.empty, bus.rvalid);
        end
        drive(1'b1, 8'h77, 1'b0);
`ifdef FIFO_FWFT_EN
        tests_run++;
        if ({bus.rvalid, bus.rdata} !== {1'b1, 8'h77}) begin
            tests_failed++;
            $display("FAIL fwft_fallthrough: rvalid %b rdata %h expected 1 77", bus.rvalid, bus.rdata);
        end
`endif
        drive(1'b0, '0, 1'b1);
`ifndef FIFO_FWFT_EN
        tests_run++;
        if (bus.rdata !== 8'h77) begin
            tests_failed++;
            $display("FAIL reset_mid_read: got %h expected 77", bus.rdata);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
